// File: rtl/coeff_token_stream_dec.sv
// coeff_token stream decoder: an MSB-aligned bit buffer feeding a one-token-per-cycle
// decoder for the nC>=8 fixed-length table (Mode=0) and the ChromaDC table (Mode=1).
module coeff_token_stream_dec #(
    parameter int IN_W  = 16,
    parameter int BUF_W = 2 * IN_W
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            InValid,
    input  logic [IN_W-1:0] InData,
    output logic            InReady,
    input  logic            Mode,
    input  logic            Flush,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [4:0]      TotalCoeff,
    output logic [1:0]      TrailingOnes,
    output logic [4:0]      NumShift,
    output logic            Error
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] ROOM   = CNT_W'(BUF_W - IN_W);
    localparam logic [CNT_W-1:0] IN_CNT = CNT_W'(IN_W);

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       tc_q, tc_d;
    logic [1:0]       t1_q, t1_d;
    logic [4:0]       ns_q, ns_d;
    logic             err_q, err_d;

    logic [5:0]       code6;
    logic [7:0]       code8;
    logic [4:0]       dec_tc;
    logic [1:0]       dec_t1;
    logic [4:0]       dec_ns;
    logic             dec_err;

    logic [CNT_W-1:0] need;
    logic [CNT_W-1:0] consumed;
    logic [CNT_W-1:0] bit_rem;
    logic [BUF_W-1:0] rem_buf;
    logic [BUF_W-1:0] keep_mask;
    logic [BUF_W-1:0] placed;
    logic             fire;
    logic             accept;

    assign code6 = buf_q[BUF_W-1 -: 6];
    assign code8 = buf_q[BUF_W-1 -: 8];

    // Token table lookup on the buffer head; only the valid head bits are examined.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec_tc  = 5'd0;
        dec_t1  = 2'd0;
        dec_ns  = 5'd6;
        dec_err = 1'b0;
        if (!Mode) begin
            if (code6 == 6'b000011) begin
                dec_tc = 5'd0;
            end else if (code6 == 6'b000010 || code6 == 6'b000111) begin
                dec_err = 1'b1;
            end else begin
                dec_tc = {1'b0, code6[5:2]} + 5'd1;
                dec_t1 = code6[1:0];
            end
        end else begin
            casez (code8)
                8'b1???????: begin dec_tc = 5'd1; dec_t1 = 2'd1; dec_ns = 5'd1; end
                8'b01??????: begin dec_tc = 5'd0; dec_t1 = 2'd0; dec_ns = 5'd2; end
                8'b001?????: begin dec_tc = 5'd2; dec_t1 = 2'd2; dec_ns = 5'd3; end
                8'b000111??: begin dec_tc = 5'd1; dec_t1 = 2'd0; dec_ns = 5'd6; end
                8'b000110??: begin dec_tc = 5'd2; dec_t1 = 2'd1; dec_ns = 5'd6; end
                8'b000101??: begin dec_tc = 5'd3; dec_t1 = 2'd3; dec_ns = 5'd6; end
                8'b000100??: begin dec_tc = 5'd2; dec_t1 = 2'd0; dec_ns = 5'd6; end
                8'b000011??: begin dec_tc = 5'd3; dec_t1 = 2'd0; dec_ns = 5'd6; end
                8'b000010??: begin dec_tc = 5'd4; dec_t1 = 2'd0; dec_ns = 5'd6; end
                8'b0000011?: begin dec_tc = 5'd3; dec_t1 = 2'd1; dec_ns = 5'd7; end
                8'b0000010?: begin dec_tc = 5'd3; dec_t1 = 2'd2; dec_ns = 5'd7; end
                8'b0000000?: begin dec_tc = 5'd4; dec_t1 = 2'd3; dec_ns = 5'd7; end
                8'b00000011: begin dec_tc = 5'd4; dec_t1 = 2'd1; dec_ns = 5'd8; end
                8'b00000010: begin dec_tc = 5'd4; dec_t1 = 2'd2; dec_ns = 5'd8; end
                default:     begin dec_tc = 5'd0; dec_t1 = 2'd0; dec_ns = 5'd8; end
            endcase
        end
    end

    // Buffer, output stage and FSM next state.
    always_comb begin
        need     = Mode ? CNT_W'(8) : CNT_W'(6);
        fire     = !Flush && (state_q == S_RUN) && (bit_cnt_q >= need)
                   && (!out_valid_q || OutReady);
        consumed = fire ? CNT_W'(dec_ns) : '0;
        bit_rem  = bit_cnt_q - consumed;
        rem_buf  = buf_q << consumed;
        // Bits below the fill level are don't-care, so clear them before merging new data.
        keep_mask = ~({BUF_W{1'b1}} >> bit_rem);
        placed    = {InData, {(BUF_W - IN_W){1'b0}}} >> bit_rem;
        InReady   = !Flush && (bit_rem <= ROOM);
        accept    = InValid && InReady;

        buf_d       = rem_buf & keep_mask;
        bit_cnt_d   = bit_rem;
        out_valid_d = out_valid_q;
        tc_d        = tc_q;
        t1_d        = t1_q;
        ns_d        = ns_q;
        err_d       = err_q;

        if (accept) begin
            buf_d     = (rem_buf & keep_mask) | placed;
            bit_cnt_d = bit_rem + IN_CNT;
        end

        if (fire) begin
            out_valid_d = 1'b1;
            tc_d        = dec_tc;
            t1_d        = dec_t1;
            ns_d        = dec_ns;
            err_d       = dec_err;
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end

        state_d = (bit_cnt_d >= need) ? S_RUN : S_FILL;

        if (Flush) begin
            buf_d       = '0;
            bit_cnt_d   = '0;
            out_valid_d = 1'b0;
            state_d     = S_FILL;
        end
    end

    // NOTE: the bit buffer is an ordinary register, not a RAM, so it is reset along with the rest.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_FILL;
            buf_q       <= '0;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            tc_q        <= 5'd0;
            t1_q        <= 2'd0;
            ns_q        <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            buf_q       <= buf_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            tc_q        <= tc_d;
            t1_q        <= t1_d;
            ns_q        <= ns_d;
            err_q       <= err_d;
        end
    end

    assign OutValid     = out_valid_q;
    assign TotalCoeff   = tc_q;
    assign TrailingOnes = t1_q;
    assign NumShift     = ns_q;
    assign Error        = err_q;

endmodule

// File: tb/tb_coeff_token_stream_dec.sv
// Directed bench for coeff_token_stream_dec (IN_W=16): token tables, stalls, flush and reset.
module tb_coeff_token_stream_dec;

    typedef struct packed {
        logic [4:0] tc;
        logic [1:0] t1;
        logic [4:0] ns;
        logic       err;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  tc;
    logic [1:0]  t1;
    logic [4:0]  ns;
    logic        err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    tok_t tq[$];
    int   cq[$];
    logic [15:0] wbuf[4];

    coeff_token_stream_dec #(.IN_W(16), .BUF_W(32)) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .InValid     (in_valid),
        .InData      (in_data),
        .InReady     (in_ready),
        .Mode        (mode),
        .Flush       (flush),
        .OutValid    (out_valid),
        .OutReady    (out_ready),
        .TotalCoeff  (tc),
        .TrailingOnes(t1),
        .NumShift    (ns),
        .Error       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tq.push_back(tok_t'{tc, t1, ns, err});
            cq.push_back(cyc);
        end
    end

    function automatic tok_t mk(input int tc_v, input int t1_v, input int ns_v, input int e_v);
        tok_t t;
        t.tc  = tc_v[4:0];
        t.t1  = t1_v[1:0];
        t.ns  = ns_v[4:0];
        t.err = e_v[0];
        return t;
    endfunction

    function automatic string tok_str(input tok_t t);
        return $sformatf("(tc=%0d t1=%0d ns=%0d err=%0d)", t.tc, t.t1, t.ns, t.err);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        tq.delete();
        cq.delete();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_q();
    endtask

    task automatic send_words(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            in_valid = 1'b1;
            in_data  = wbuf[i];
            @(negedge clk);
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s word%0d: InReady=%b after 50 cycles, required 1", name, i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_tokens(input int n, input string name);
        int k = 0;
        while (tq.size() < n && k < 200) begin
            tick();
            k++;
        end
        n_checks++;
        if (tq.size() < n) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d tokens, required %0d", name, tq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, tc, t1, ns, err} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h, required 0", {out_valid, tc, t1, ns, err});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_valid: got %b, required 0", out_valid);
        end
        tick();
    endtask

    task automatic run_0c4f(input string name);
        tok_t e[5];
        e = '{mk(0, 0, 6, 0), mk(2, 0, 6, 0), mk(16, 3, 6, 0), mk(1, 0, 6, 0), mk(1, 0, 6, 0)};
        mode      = 1'b0;
        out_ready = 1'b1;
        clear_q();
        wbuf[0] = 16'h0C4F;
        wbuf[1] = 16'hC000;
        send_words(2, name);
        wait_tokens(5, name);
        repeat (5) tick();
        n_checks++;
        if (tq.size() != 5) begin
            n_fail++;
            $display("FAIL %s count: got %0d tokens, required 5", name, tq.size());
        end
        for (int i = 0; i < 5 && i < tq.size(); i++) begin
            n_checks++;
            if (tq[i] !== e[i]) begin
                n_fail++;
                $display("FAIL %s tok%0d: got %s required %s", name, i, tok_str(tq[i]), tok_str(e[i]));
            end
        end
        for (int i = 1; i < 3 && i < cq.size(); i++) begin
            n_checks++;
            if (cq[i] !== cq[i-1] + 1) begin
                n_fail++;
                $display("FAIL %s rate%0d: got cycle %0d, required %0d", name, i, cq[i], cq[i-1] + 1);
            end
        end
        do_flush();
    endtask

    task automatic test_mode0_stream();
        run_0c4f("mode0_stream");
    endtask

    task automatic test_mode1_stream();
        tok_t e[5];
        e = '{mk(1, 1, 1, 0), mk(0, 0, 2, 0), mk(2, 2, 3, 0), mk(4, 3, 7, 0), mk(4, 1, 8, 0)};
        mode      = 1'b1;
        out_ready = 1'b1;
        clear_q();
        wbuf[0] = 16'hA400;
        wbuf[1] = 16'h1800;
        send_words(2, "mode1_stream");
        wait_tokens(5, "mode1_stream");
        for (int i = 0; i < 5 && i < tq.size(); i++) begin
            n_checks++;
            if (tq[i] !== e[i]) begin
                n_fail++;
                $display("FAIL mode1_stream tok%0d: got %s required %s", i, tok_str(tq[i]), tok_str(e[i]));
            end
        end
        do_flush();
        mode = 1'b0;
    endtask

    task automatic test_error();
        tok_t e[4];
        e = '{mk(0, 0, 6, 1), mk(1, 0, 6, 0), mk(0, 0, 6, 1), mk(1, 0, 6, 0)};
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            clear_q();
            wbuf[0] = (r == 0) ? 16'h0800 : 16'h1C00;
            send_words(1, "error");
            wait_tokens(2, "error");
            repeat (4) tick();
            n_checks++;
            if (tq.size() != 2) begin
                n_fail++;
                $display("FAIL error%0d count: got %0d tokens, required 2", r, tq.size());
            end
            for (int i = 0; i < 2 && i < tq.size(); i++) begin
                n_checks++;
                if (tq[i] !== e[2*r+i]) begin
                    n_fail++;
                    $display("FAIL error%0d tok%0d: got %s required %s", r, i, tok_str(tq[i]), tok_str(e[2*r+i]));
                end
            end
            do_flush();
        end
    endtask

    task automatic test_back_to_back();
        tok_t e[10];
        e = '{mk(0, 0, 6, 0), mk(2, 0, 6, 0), mk(16, 3, 6, 0), mk(1, 0, 6, 0), mk(1, 0, 6, 0),
              mk(1, 1, 6, 0), mk(3, 0, 6, 0), mk(14, 0, 6, 0), mk(11, 2, 6, 0), mk(16, 0, 6, 0)};
        wbuf = '{16'h0C4F, 16'hC000, 16'h1234, 16'hABCD};
        mode = 1'b0;
        for (int run = 0; run < 2; run++) begin
            clear_q();
            out_ready = (run == 0);
            fork
                send_words(4, "back_to_back");
                if (run == 1) begin
                    tok_t snap;
                    int   k = 0;
                    @(negedge clk);
                    while (!out_valid && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    snap = tok_t'{tc, t1, ns, err};
                    n_checks++;
                    if (snap !== e[0] || out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_head: got valid=%b %s required valid=1 %s", out_valid, tok_str(snap), tok_str(e[0]));
                    end
                    for (int c = 0; c < 10; c++) begin
                        @(negedge clk);
                        n_checks++;
                        if (tok_t'{tc, t1, ns, err} !== snap || out_valid !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stall_hold c%0d: got valid=%b %s required valid=1 %s", c, out_valid, tok_str(tok_t'{tc, t1, ns, err}), tok_str(snap));
                        end
                    end
                    n_checks++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_in_ready: got %b, required 0", in_ready);
                    end
                    tick();
                    out_ready = 1'b1;
                end
            join
            wait_tokens(10, "back_to_back");
            repeat (5) tick();
            n_checks++;
            if (tq.size() != 10) begin
                n_fail++;
                $display("FAIL back_to_back run%0d count: got %0d tokens, required 10", run, tq.size());
            end
            for (int i = 0; i < 10 && i < tq.size(); i++) begin
                n_checks++;
                if (tq[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL back_to_back run%0d tok%0d: got %s required %s", run, i, tok_str(tq[i]), tok_str(e[i]));
                end
            end
            do_flush();
        end
    endtask

    task automatic test_flush();
        mode      = 1'b0;
        out_ready = 1'b1;
        clear_q();
        in_valid = 1'b1;
        in_data  = 16'h0C4F;
        tick();
        in_data = 16'hC000;
        tick();
        in_valid = 1'b0;
        tick();
        flush     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle: got in_ready=%b valid=%b, required 0 and 1", in_ready, out_valid);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after: got valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
        end
        tick();
        out_ready = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (tq.size() != 1) begin
            n_fail++;
            $display("FAIL flush_leak: got %0d tokens, required 1", tq.size());
        end
        clear_q();
        wbuf[0] = 16'h0C4F;
        send_words(1, "flush_fresh");
        wait_tokens(1, "flush_fresh");
        if (tq.size() > 0) begin
            n_checks++;
            if (tq[0] !== mk(0, 0, 6, 0)) begin
                n_fail++;
                $display("FAIL flush_fresh: got %s required %s", tok_str(tq[0]), tok_str(mk(0, 0, 6, 0)));
            end
        end
        do_flush();
    endtask

    task automatic test_reset_mid();
        mode      = 1'b0;
        out_ready = 1'b0;
        clear_q();
        wbuf[0] = 16'h0C4F;
        wbuf[1] = 16'hC000;
        send_words(2, "reset_mid");
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, tc, t1, ns, err} !== 14'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_async: got outputs=%0h in_ready=%b, required 0 and 1", {out_valid, tc, t1, ns, err}, in_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        run_0c4f("reset_rerun");
    endtask

    initial begin
        test_reset();
        test_mode0_stream();
        test_mode1_stream();
        test_error();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
